// File: rtl/conv_window_multiplier.sv
// 3x3 sliding-window front end for the nine-input adder_tree: two line buffers feed a window
// whose taps are multiplied by stored Q8.8 weights into nine registered Q8.8 products.
module conv_window_multiplier #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned IMG_WIDTH  = 28,
  parameter int unsigned IMG_HEIGHT = 28
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic signed [DATA_WIDTH-1:0] pixel_in,
  input  logic                         pixel_valid,
  input  logic                         weight_we,
  input  logic        [3:0]            weight_addr,
  input  logic signed [DATA_WIDTH-1:0] weight_data,
  output logic signed [DATA_WIDTH-1:0] product_0,
  output logic signed [DATA_WIDTH-1:0] product_1,
  output logic signed [DATA_WIDTH-1:0] product_2,
  output logic signed [DATA_WIDTH-1:0] product_3,
  output logic signed [DATA_WIDTH-1:0] product_4,
  output logic signed [DATA_WIDTH-1:0] product_5,
  output logic signed [DATA_WIDTH-1:0] product_6,
  output logic signed [DATA_WIDTH-1:0] product_7,
  output logic signed [DATA_WIDTH-1:0] product_8,
  output logic                         out_valid,
  output logic                         out_last
);

  localparam int unsigned ColW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RowW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  typedef logic signed [DATA_WIDTH-1:0] data_t;

  logic [ColW-1:0] col_q, col_d;
  logic [RowW-1:0] row_q, row_d;
  logic            v1_q, last1_q, out_valid_q, out_last_q;
  logic            win_ok, is_last;

  data_t lb1_q [IMG_WIDTH];
  data_t lb2_q [IMG_WIDTH];
  data_t win_q [3][3];
  data_t weight_q [9];
  data_t prod_q [9];
  data_t prod_d [9];
  logic signed [2*DATA_WIDTH-1:0] full [9];

  assign win_ok  = (row_q >= RowW'(2)) && (col_q >= ColW'(2));
  assign is_last = (row_q == RowW'(IMG_HEIGHT-1)) && (col_q == ColW'(IMG_WIDTH-1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (pixel_valid) begin
      if (col_q == ColW'(IMG_WIDTH-1)) begin
        col_d = '0;
        row_d = (row_q == RowW'(IMG_HEIGHT-1)) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Q8.8 x Q8.8 = Q16.16; keep the middle bits, truncating and wrapping.
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      full[k]   = win_q[k/3][k%3] * weight_q[k];
      prod_d[k] = full[k][DATA_WIDTH+7:8];
    end
  end

  // Data path storage is deliberately unreset; output gating hides stale contents.
  always_ff @(posedge clk) begin
    if (rst_n && pixel_valid) begin
      lb1_q[0] <= pixel_in;
      lb2_q[0] <= lb1_q[IMG_WIDTH-1];
      for (int i = 1; i < IMG_WIDTH; i++) begin
        lb1_q[i] <= lb1_q[i-1];
        lb2_q[i] <= lb2_q[i-1];
      end
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb2_q[IMG_WIDTH-1];
      win_q[1][2] <= lb1_q[IMG_WIDTH-1];
      win_q[2][2] <= pixel_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      for (int k = 0; k < 9; k++) begin
        weight_q[k] <= '0;
        prod_q[k]   <= '0;
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      v1_q        <= pixel_valid && win_ok;
      last1_q     <= pixel_valid && is_last;
      out_valid_q <= v1_q;
      out_last_q  <= v1_q && last1_q;
      for (int k = 0; k < 9; k++) begin
        if (weight_we && (weight_addr == 4'(k))) weight_q[k] <= weight_data;
        if (v1_q) prod_q[k] <= prod_d[k];
      end
    end
  end

  assign product_0 = prod_q[0];
  assign product_1 = prod_q[1];
  assign product_2 = prod_q[2];
  assign product_3 = prod_q[3];
  assign product_4 = prod_q[4];
  assign product_5 = prod_q[5];
  assign product_6 = prod_q[6];
  assign product_7 = prod_q[7];
  assign product_8 = prod_q[8];
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_conv_window_multiplier.sv
// Directed bench for conv_window_multiplier on a 4x4 image with immediate-assertion checks.
module tb_conv_window_multiplier;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pixel_in;
  logic        pixel_valid;
  logic        weight_we;
  logic [3:0]  weight_addr;
  logic [15:0] weight_data;
  logic [15:0] product_0, product_1, product_2, product_3, product_4;
  logic [15:0] product_5, product_6, product_7, product_8;
  logic        out_valid, out_last;
  logic [15:0] prod [9];

  int n_cmp = 0;
  int n_err = 0;

  // Bench-side model state
  logic [15:0] cur_frame [16];
  logic [15:0] exp_w [9];
  logic [15:0] pend_exp [9];
  logic [15:0] held [9];
  logic [15:0] first_prod [9];
  logic        pend_v, pend_l, gap_mode, prev_ov, got_first;
  int          vcnt, lcnt;

  logic [15:0] ramp_first [9] = '{16'h0000, 16'h0100, 16'h0200, 16'h0400, 16'h0500,
                                  16'h0600, 16'h0800, 16'h0900, 16'h0A00};

  always #5 clk = ~clk;

  conv_window_multiplier #(
    .DATA_WIDTH(16),
    .IMG_WIDTH (4),
    .IMG_HEIGHT(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pixel_in   (pixel_in),
    .pixel_valid(pixel_valid),
    .weight_we  (weight_we),
    .weight_addr(weight_addr),
    .weight_data(weight_data),
    .product_0  (product_0),
    .product_1  (product_1),
    .product_2  (product_2),
    .product_3  (product_3),
    .product_4  (product_4),
    .product_5  (product_5),
    .product_6  (product_6),
    .product_7  (product_7),
    .product_8  (product_8),
    .out_valid  (out_valid),
    .out_last   (out_last)
  );

  assign prod[0] = product_0;
  assign prod[1] = product_1;
  assign prod[2] = product_2;
  assign prod[3] = product_3;
  assign prod[4] = product_4;
  assign prod[5] = product_5;
  assign prod[6] = product_6;
  assign prod[7] = product_7;
  assign prod[8] = product_8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Compare outputs after an edge against the window accepted one edge earlier.
  task automatic observe();
    chk("out_valid", {31'b0, out_valid}, {31'b0, pend_v});
    chk("out_last", {31'b0, out_last}, {31'b0, pend_v & pend_l});
    for (int k = 0; k < 9; k++) begin
      if (pend_v) held[k] = pend_exp[k];
      chk($sformatf("product_%0d", k), {16'b0, prod[k]}, {16'b0, held[k]});
    end
    if (gap_mode) chk("no_back_to_back", {31'b0, out_valid & prev_ov}, 32'd0);
    if (out_valid && !got_first) begin
      for (int k = 0; k < 9; k++) first_prod[k] = prod[k];
      got_first = 1'b1;
    end
    vcnt    += int'(out_valid);
    lcnt    += int'(out_last);
    prev_ov  = out_valid;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    observe();
    pend_v = 1'b0;
  endtask

  task automatic clr();
    vcnt      = 0;
    lcnt      = 0;
    got_first = 1'b0;
    prev_ov   = 1'b0;
  endtask

  task automatic wr_weight(input logic [3:0] a, input logic [15:0] d);
    weight_we   = 1'b1;
    weight_addr = a;
    weight_data = d;
    if (a <= 4'd8) exp_w[a] = d;
    step();
    weight_we = 1'b0;
  endtask

  task automatic load_unity();
    for (int k = 0; k < 9; k++) wr_weight(4'(k), 16'h0100);
  endtask

  task automatic fill_ramp(input int base);
    for (int i = 0; i < 16; i++) cur_frame[i] = 16'((base + i) << 8);
  endtask

  task automatic stream(input int npix, input bit gapped, input bit coll);
    logic signed [31:0] full;
    int rr, cc;
    gap_mode = gapped;
    for (int i = 0; i < npix; i++) begin
      if (gapped && i > 0) begin
        pixel_valid = 1'b0;
        step();
      end
      pixel_in    = cur_frame[i];
      pixel_valid = 1'b1;
      if (coll && i == 10) begin
        weight_we   = 1'b1;
        weight_addr = 4'd8;
        weight_data = 16'h0200;
        exp_w[8]    = 16'h0200;
      end
      step();
      weight_we = 1'b0;
      pend_v = (i / 4 >= 2) && (i % 4 >= 2);
      pend_l = (i == 15);
      if (pend_v) begin
        for (int k = 0; k < 9; k++) begin
          rr   = i / 4 - 2 + k / 3;
          cc   = i % 4 - 2 + k % 3;
          full = $signed(cur_frame[rr*4+cc]) * $signed(exp_w[k]);
          pend_exp[k] = full[23:8];
        end
      end
    end
  endtask

  task automatic flush();
    pixel_valid = 1'b0;
    step();
    gap_mode = 1'b0;
  endtask

  // Reset edge with pixel and weight activity present to exercise precedence.
  task automatic do_reset();
    rst_n       = 1'b0;
    pixel_valid = 1'b1;
    pixel_in    = 16'h5555;
    weight_we   = 1'b1;
    weight_addr = 4'd0;
    weight_data = 16'h1234;
    pend_v      = 1'b0;
    for (int k = 0; k < 9; k++) begin
      held[k]  = 16'h0000;
      exp_w[k] = 16'h0000;
    end
    step();
    rst_n       = 1'b1;
    pixel_valid = 1'b0;
    weight_we   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pixel_in = '0; pixel_valid = 1'b0;
    weight_we = 1'b0; weight_addr = '0; weight_data = '0;
    pend_v = 1'b0; pend_l = 1'b0; gap_mode = 1'b0;
    clr();
    do_reset();

    // Ramp frame, unity weights; the address-12 write must change nothing
    load_unity();
    wr_weight(4'd12, 16'h7777);
    fill_ramp(0);
    clr();
    stream(16, 1'b0, 1'b0);
    flush();
    chk("ramp_valid_count", 32'(vcnt), 32'd4);
    chk("ramp_last_count", 32'(lcnt), 32'd1);
    for (int k = 0; k < 9; k++)
      chk($sformatf("ramp_first_%0d", k), {16'b0, first_prod[k]}, {16'b0, ramp_first[k]});

    // Gapped stream
    clr();
    stream(16, 1'b1, 1'b0);
    flush();
    chk("gap_valid_count", 32'(vcnt), 32'd4);
    chk("gap_last_count", 32'(lcnt), 32'd1);
    for (int k = 0; k < 9; k++)
      chk($sformatf("gap_first_%0d", k), {16'b0, first_prod[k]}, {16'b0, ramp_first[k]});

    // Signed and wrapping arithmetic
    wr_weight(4'd0, 16'hFF80);
    wr_weight(4'd4, 16'h0200);
    for (int i = 0; i < 16; i++) cur_frame[i] = 16'h0300;
    cur_frame[5] = 16'h7F00;
    clr();
    stream(16, 1'b0, 1'b0);
    flush();
    chk("signed_product_0", {16'b0, first_prod[0]}, 32'h0000FE80);
    chk("wrap_product_4", {16'b0, first_prod[4]}, 32'h0000FE00);

    // Weight write on the edge accepting pixel (2,2)
    load_unity();
    fill_ramp(0);
    clr();
    stream(16, 1'b0, 1'b1);
    flush();
    chk("collision_product_8", {16'b0, first_prod[8]}, 32'h00001400);

    // Reset mid-frame after pixel (2,3)
    load_unity();
    clr();
    stream(12, 1'b0, 1'b0);
    do_reset();
    clr();
    stream(16, 1'b0, 1'b0);
    flush();
    chk("post_reset_valid_count", 32'(vcnt), 32'd4);
    chk("post_reset_zero_prod_8", {16'b0, first_prod[8]}, 32'd0);
    load_unity();
    clr();
    stream(16, 1'b0, 1'b0);
    flush();
    for (int k = 0; k < 9; k++)
      chk($sformatf("restart_first_%0d", k), {16'b0, first_prod[k]}, {16'b0, ramp_first[k]});

    // Two frames back to back, second frame with distinct values
    clr();
    fill_ramp(0);
    stream(16, 1'b0, 1'b0);
    fill_ramp(16);
    stream(16, 1'b0, 1'b0);
    flush();
    chk("wrap_valid_count", 32'(vcnt), 32'd8);
    chk("wrap_last_count", 32'(lcnt), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_window_multiplier.md
# conv_window_multiplier

Streaming front end that feeds the nine-input `adder_tree`. It accepts a raster-order pixel stream and holds a 3×3 sliding window using two line buffers. It multiplies each window tap by a stored Q8.8 kernel weight and presents nine registered Q8.8 products, with a valid strobe, on the `adder_tree` `data_in_0..data_in_8` inputs. Bias is supplied separately, outside this block.

## Interface
- `DATA_WIDTH`, 16: pixel, weight and product width; signed Q8.8, scale 2^-8.
- `IMG_WIDTH`, 28: pixels per row; minimum 3.
- `IMG_HEIGHT`, 28: rows per frame; minimum 3.
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `pixel_in`  in  DATA_WIDTH  signed Q8.8 pixel, raster order.
- `pixel_valid`  in  1  `pixel_in` is accepted on this edge. No backpressure exists.
- `weight_we`  in  1  weight write enable.
- `weight_addr`  in  4  kernel tap index 0..8. Writes to 9..15 are ignored.
- `weight_data`  in  DATA_WIDTH  signed Q8.8 weight.
- `product_0..product_8`  out  DATA_WIDTH each  registered products; connect to `adder_tree` `data_in_0..8`.
- `out_valid`  out  1  products are a complete new window this cycle.
- `out_last`  out  1  with `out_valid`, marks the window ending at pixel (IMG_HEIGHT-1, IMG_WIDTH-1).

## Operation
- **Counters.**
  - `col` runs 0..IMG_WIDTH-1 and `row` runs 0..IMG_HEIGHT-1.
  - Both advance only on accepted pixels.
  - `col` wraps to 0 and increments `row`.
  - `row` wraps to 0 after the last pixel of a frame; the next pixel starts a new frame.
- **Line buffers.**
  - Two shift registers, each IMG_WIDTH deep, hold rows row-1 and row-2.
  - They shift only on accepted pixels.
  - Contents are not reset. Stale data is never emitted because output gating (below) covers it.
- **Window.**
  - Index w[r][c]: r=0 is row-2, r=2 is the current row; c=0 is col-2, c=2 is the current column.
  - After the pixel at (row,col) is accepted, the window covers rows row-2..row and cols col-2..col.
- **Tap mapping.** k = 3r + c. `product_k` = w[r][c] × weight[k].
- **Arithmetic.**
  - Full 2·DATA_WIDTH signed product.
  - Take bits [DATA_WIDTH+7:8], i.e. an arithmetic shift right by 8, truncated.
  - No rounding and no saturation. Overflow wraps, matching `adder_tree` wrap semantics.
- **Window valid.** A window is valid when the accepted pixel has row ≥ 2 and col ≥ 2. This gives (IMG_WIDTH-2)·(IMG_HEIGHT-2) windows per frame.
- **Weights.**
  - Nine registers, written on an edge when `weight_we`=1 and `weight_addr` ≤ 8.
  - A write lands on the same edge, so a multiply on the following edge uses the new value.
  - A write to a tap on the same edge as that tap's multiply: the multiply uses the old value.

## Timing
- Two-stage pipeline, no stall.
- **Stage 1, edge N** (pixel accepted):
  - Shift the window and line buffers; update the counters.
  - Set `v1` = window valid and `last1` = (row,col) is the final pixel.
- **Stage 2, edge N+1:**
  - If `v1`: register all nine products, set `out_valid`=1, set `out_last`=`last1`.
  - Else: products hold their previous value, and `out_valid`=0, `out_last`=0.
- **Latency.** Pixel presented in cycle N, products visible in cycle N+1 after edge N+1. One window per accepted pixel at most, so full throughput is one window per clock.
- **`pixel_valid`=0 gaps.** Window and counters hold. `out_valid` drops for exactly the corresponding cycle(s).
- **Reset.** Sampled low at an edge, it sets:
  - `col`, `row`, `v1`, `last1` to 0;
  - all weights to 0;
  - all products to 0;
  - `out_valid` and `out_last` to 0.
- **Reset mid-frame.** The in-flight window is discarded. The next accepted pixel is (0,0), and no `out_valid` occurs until (2,2) of the new frame.
- **Reset precedence.** Reset overrides a simultaneous `pixel_valid` or `weight_we`.

## Test plan
Bench overrides IMG_WIDTH=4 and IMG_HEIGHT=4 unless stated.

1. **Ramp frame, unity weights.** All weights 0x0100; pixel (r,c) = (4r+c)<<8, streamed back-to-back.
   - First `out_valid` is 2 cycles after presenting (2,2).
   - Products are 0x0000, 0x0100, 0x0200, 0x0400, 0x0500, 0x0600, 0x0800, 0x0900, 0x0A00.
   - Exactly 4 `out_valid` pulses; `out_last` only with the window ending at pixel 15, whose `product_8` = 0x0F00.
2. **Signed and wrap arithmetic.**
   - weight[0]=0xFF80 (-0.5) with all window pixels 0x0300 → `product_0`=0xFE80 (-1.5).
   - weight[4]=0x0200 with pixel 0x7F00 → `product_4`=0xFE00 (wrapped, no saturation).
3. **Gapped stream.** Same frame as scenario 1 with `pixel_valid` toggling 1,0,1,0.
   - Identical product values and count to scenario 1.
   - `out_valid` is never asserted in two consecutive cycles.
4. **Weight write collision.** Write weight[8]=0x0200 on the edge where pixel (2,2) is accepted → that window's `product_8`=0x1400. Write to address 12 → no weight changes.
5. **Reset mid-frame.** Assert `rst_n`=0 for one edge after pixel (2,3).
   - `out_valid`=0 and all products/weights 0 next cycle.
   - Reload weights, restart the frame: first window matches scenario 1.
6. **Frame wrap.** Two consecutive frames with no gap: 8 `out_valid` pulses, 2 `out_last` pulses, second-frame products correct and unaffected by first-frame line-buffer contents.
